ysyx_24080014_ifu: RTL and testbench

Instruction fetch unit directly downstream of the PC register. Takes the current pc and issues one read on the instruction-memory request/response bus. Holds the returned word for the decode stage under a valid/ready handshake, and pulses pc_advance when decode accepts, which lets the PC register load next_pc. It is multicycle: one instruction is in flight at a time, a flush input supports redirects, and a fault path covers misaligned pc and bus errors/timeouts.

---
 rtl/ysyx_24080014_ifu.sv | 141 ++++++++++++++
 tb/tb_ysyx_24080014_ifu.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080014_ifu.sv
// Multicycle instruction fetch: one bus read per pc, result held for decode under
// valid/ready, with flush redirect and a fault path for misalignment, bus error and timeout.
module ysyx_24080014_ifu #(
    parameter int          XLEN       = 32,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] FAULT_INST = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    input  logic            flush_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_fault_o,
    output logic            pc_advance_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              fault_q, fault_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              orphan_q, orphan_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            inst_pc_q <= '0;
            inst_q    <= '0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
            orphan_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            inst_pc_q <= inst_pc_d;
            inst_q    <= inst_d;
            fault_q   <= fault_d;
            cnt_q     <= cnt_d;
            orphan_q  <= orphan_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        inst_pc_d = inst_pc_q;
        inst_d    = inst_q;
        fault_d   = fault_q;
        cnt_d     = cnt_q;
        orphan_d  = orphan_q;
        unique case (state_q)
            S_IDLE: begin
                if (pc_valid_i && !flush_i) begin
                    addr_d    = pc_i;
                    inst_pc_d = pc_i;
                    if (pc_i[1:0] != 2'b00) begin
                        inst_d  = FAULT_INST;
                        fault_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Once the bus has taken the request its response must be drained.
                if (imem_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = flush_i ? S_DROP : S_WAIT;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid_i) begin
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        inst_d  = imem_rsp_err_i ? FAULT_INST : imem_rsp_data_i;
                        fault_d = imem_rsp_err_i;
                        state_d = S_HOLD;
                    end
                end else if (flush_i) begin
                    state_d = S_DROP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    // The late response is still owed; swallow it after decode takes the fault.
                    inst_d   = FAULT_INST;
                    fault_d  = 1'b1;
                    orphan_d = 1'b1;
                    state_d  = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (flush_i || inst_ready_i) begin
                    state_d = orphan_q ? S_DROP : S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid_i) begin
                    orphan_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req_valid_o = (state_q == S_REQ);
    assign imem_req_addr_o  = addr_q;
    assign inst_valid_o     = (state_q == S_HOLD);
    assign inst_o           = inst_q;
    assign inst_pc_o        = inst_pc_q;
    assign inst_fault_o     = fault_q;
    assign pc_advance_o     = (state_q == S_HOLD) && inst_ready_i && !flush_i;

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// Bench for the fetch unit: directed vector table, hand-written corner sequences,
// then random bus/decode traffic checked against a pc-level reference model.
module tb_ysyx_24080014_ifu;
    localparam int          TO  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] pc, req_addr, rsp_data, inst, inst_pc;
    logic pc_valid, flush, req_valid, req_ready, rsp_valid, rsp_err;
    logic inst_valid, inst_ready, inst_fault, pc_advance;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24080014_ifu #(.XLEN(32), .TIMEOUT(TO), .FAULT_INST(NOP)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .pc_valid_i(pc_valid), .flush_i(flush),
        .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(req_addr),
        .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data), .imem_rsp_err_i(rsp_err),
        .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_o(inst),
        .inst_pc_o(inst_pc), .inst_fault_o(inst_fault), .pc_advance_o(pc_advance)
    );

    typedef struct {
        logic [31:0] pc;
        logic        pv, fl, rr, rv;
        logic [31:0] rd;
        logic        ir;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_in, e_ipc;
        logic        e_f, e_adv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [31:0] p, input logic pv, fl, rr, rv,
                                input logic [31:0] rd, input logic ir, e_rv,
                                input logic [31:0] e_ra, input logic e_iv,
                                input logic [31:0] e_in, e_ipc, input logic e_f, e_adv);
        vec_t v;
        v.pc = p; v.pv = pv; v.fl = fl; v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir;
        v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv; v.e_in = e_in; v.e_ipc = e_ipc;
        v.e_f = e_f; v.e_adv = e_adv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic quiet();
        pc_valid = 0; flush = 0; req_ready = 0; rsp_valid = 0;
        rsp_data = 0; rsp_err = 0; inst_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " req_valid"}, {31'b0, req_valid}, 0);
        chk({tag, " req_addr"}, req_addr, 0);
        chk({tag, " inst_valid"}, {31'b0, inst_valid}, 0);
        chk({tag, " inst"}, inst, 0);
        chk({tag, " inst_pc"}, inst_pc, 0);
        chk({tag, " inst_fault"}, {31'b0, inst_fault}, 0);
        chk({tag, " pc_advance"}, {31'b0, pc_advance}, 0);
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] ei, ep, input logic ef);
        chk({tag, " inst_valid"}, {31'b0, inst_valid}, 1);
        chk({tag, " inst"}, inst, ei);
        chk({tag, " inst_pc"}, inst_pc, ep);
        chk({tag, " inst_fault"}, {31'b0, inst_fault}, {31'b0, ef});
    endtask

    // Memory image seen by the random phase.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [31:0] newpc();
        logic [31:0] p;
        p = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
        if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
        return p;
    endfunction

    // Random-phase model: the IFU must deliver mem[pc] (or a fault) for the
    // pc the bench currently holds; bench pc moves only on accept or flush.
    logic [31:0] pcr, oaddr, cdata;
    bit          out_b, late, rel, oerr, cerr;
    int          cnt, lat, rcnt, cst, deliv;
    logic        p_rv, p_rr, p_fl, p_iv, p_ir, p_f;
    logic [31:0] p_ra, p_in, p_ipc;

    initial begin
        vec_t v;
        bit   acc, hs, fresh;

        rst_n = 0; pc = 0; quiet();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1;

        //      pc            pv fl rr rv rd            ir  erv era           eiv ein           eipc          ef eadv
        tbl.push_back(mk(32'h80000000, 1, 0, 1, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000000, 1, 0, 1, 0, 32'h0,        0,  1, 32'h80000000, 0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000000, 1, 0, 1, 1, 32'h00100093, 0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000000, 0, 0, 0, 0, 32'h0,        1,  0, 32'h0,        1, 32'h00100093, 32'h80000000, 0, 1));
        tbl.push_back(mk(32'h80000000, 0, 0, 0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000002, 1, 0, 1, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000002, 0, 0, 1, 0, 32'h0,        0,  0, 32'h0,        1, NOP,          32'h80000002, 1, 0));
        tbl.push_back(mk(32'h80000002, 0, 0, 1, 0, 32'h0,        1,  0, 32'h0,        1, NOP,          32'h80000002, 1, 1));
        tbl.push_back(mk(32'h80000002, 0, 0, 0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000008, 1, 0, 1, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000008, 1, 0, 1, 0, 32'h0,        0,  1, 32'h80000008, 0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000010, 1, 1, 0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000010, 1, 0, 0, 1, 32'hDEADBEEF, 0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000010, 1, 0, 1, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000010, 1, 0, 1, 0, 32'h0,        0,  1, 32'h80000010, 0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000010, 0, 0, 0, 1, 32'h00200113, 0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(32'h80000010, 0, 0, 0, 0, 32'h0,        1,  0, 32'h0,        1, 32'h00200113, 32'h80000010, 0, 1));
        tbl.push_back(mk(32'h80000010, 0, 0, 0, 0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            pc = v.pc; pc_valid = v.pv; flush = v.fl; req_ready = v.rr;
            rsp_valid = v.rv; rsp_data = v.rd; rsp_err = 0; inst_ready = v.ir;
            @(negedge clk);
            chk($sformatf("v%0d req_valid", i), {31'b0, req_valid}, {31'b0, v.e_rv});
            if (v.e_rv) chk($sformatf("v%0d req_addr", i), req_addr, v.e_ra);
            chk($sformatf("v%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, v.e_iv});
            if (v.e_iv) begin
                chk($sformatf("v%0d inst", i), inst, v.e_in);
                chk($sformatf("v%0d inst_pc", i), inst_pc, v.e_ipc);
                chk($sformatf("v%0d inst_fault", i), {31'b0, inst_fault}, {31'b0, v.e_f});
            end
            chk($sformatf("v%0d pc_advance", i), {31'b0, pc_advance}, {31'b0, v.e_adv});
            tick();
        end
        quiet();

        // Slow handshakes on both sides; pc wiggles after sampling.
        pc = 32'h80000020; pc_valid = 1;
        @(negedge clk); tick();
        pc = 32'hFFFF_FFF0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("slow req_valid %0d", k), {31'b0, req_valid}, 1);
            chk($sformatf("slow req_addr %0d", k), req_addr, 32'h80000020);
            tick();
        end
        req_ready = 1;
        @(negedge clk); chk("slow req_valid hs", {31'b0, req_valid}, 1); tick();
        req_ready = 0; pc_valid = 0;
        @(negedge clk); chk("slow wait req_valid", {31'b0, req_valid}, 0); tick();
        rsp_valid = 1; rsp_data = 32'h00500293;
        @(negedge clk); tick();
        rsp_valid = 0; rsp_data = 32'h0BAD_0BAD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_inst($sformatf("slow hold %0d", k), 32'h00500293, 32'h80000020, 0);
            chk($sformatf("slow hold adv %0d", k), {31'b0, pc_advance}, 0);
            tick();
        end
        inst_ready = 1;
        @(negedge clk); chk("slow adv", {31'b0, pc_advance}, 1); tick();
        inst_ready = 0;
        @(negedge clk);
        chk("slow adv after", {31'b0, pc_advance}, 0);
        chk("slow iv after", {31'b0, inst_valid}, 0);
        tick();

        // Timeout, then the orphaned response is swallowed in DROP.
        pc = 32'h80000030; pc_valid = 1; req_ready = 1;
        @(negedge clk); tick();
        pc_valid = 0;
        @(negedge clk); chk("to req_valid", {31'b0, req_valid}, 1); tick();
        for (int k = 0; k < TO; k++) begin
            @(negedge clk); chk($sformatf("to wait iv %0d", k), {31'b0, inst_valid}, 0); tick();
        end
        inst_ready = 1;
        @(negedge clk);
        chk_inst("to fault", NOP, 32'h80000030, 1);
        chk("to adv", {31'b0, pc_advance}, 1);
        tick();
        inst_ready = 0; pc = 32'h80000040; pc_valid = 1;
        for (int k = 0; k < 3; k++) begin
            flush = (k == 0);
            @(negedge clk);
            chk($sformatf("drop req_valid %0d", k), {31'b0, req_valid}, 0);
            chk($sformatf("drop iv %0d", k), {31'b0, inst_valid}, 0);
            tick();
        end
        flush = 0; rsp_valid = 1; rsp_data = 32'hCAFEBABE;
        @(negedge clk); tick();
        rsp_valid = 0;
        @(negedge clk); tick();
        @(negedge clk);
        chk("post-drop req_valid", {31'b0, req_valid}, 1);
        chk("post-drop req_addr", req_addr, 32'h80000040);
        tick();
        pc_valid = 0; rsp_valid = 1; rsp_data = 32'h00300193;
        @(negedge clk); tick();
        rsp_valid = 0; inst_ready = 1;
        @(negedge clk); chk_inst("post-drop", 32'h00300193, 32'h80000040, 0); tick();
        inst_ready = 0;

        // Asynchronous reset in WAIT, applied and released off the clock edge.
        pc = 32'h80000050; pc_valid = 1; req_ready = 1;
        @(negedge clk); tick();
        @(negedge clk); tick();
        pc_valid = 0; req_ready = 0;
        #3 rst_n = 0;
        #1 chk_zero("async rst");
        @(negedge clk);
        #2 rst_n = 1;
        tick();
        rsp_valid = 1; rsp_data = 32'h1111_1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst iv %0d", k), {31'b0, inst_valid}, 0);
            chk($sformatf("post-rst req %0d", k), {31'b0, req_valid}, 0);
            tick();
            rsp_valid = 0;
        end
        pc = 32'h80000060; pc_valid = 1; req_ready = 1;
        @(negedge clk); tick();
        @(negedge clk); chk("post-rst fetch addr", req_addr, 32'h80000060); tick();
        pc_valid = 0; rsp_valid = 1; rsp_data = 32'h00400213;
        @(negedge clk); tick();
        rsp_valid = 0; inst_ready = 1;
        @(negedge clk); chk_inst("post-rst fetch", 32'h00400213, 32'h80000060, 0); tick();
        quiet();

        // Random traffic.
        pcr = newpc(); cst = 0; out_b = 0; late = 0; rel = 0; cnt = 0; lat = 0; rcnt = 0;
        oaddr = 0; oerr = 0; cdata = 0; cerr = 0; deliv = 0;
        p_rv = 0; p_rr = 0; p_fl = 0; p_iv = 0; p_ir = 0; p_f = 0;
        p_ra = 0; p_in = 0; p_ipc = 0;
        for (int c = 0; c < 3000; c++) begin
            pc = pcr;
            pc_valid   = ($urandom_range(0, 9) != 0);
            req_ready  = ($urandom_range(0, 2) != 0);
            inst_ready = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            rsp_valid  = out_b && (late ? (rel && rcnt == 0) : (cnt == lat));
            rsp_data   = rsp_valid ? memf(oaddr) : $urandom;
            rsp_err    = rsp_valid ? oerr : 1'($urandom_range(0, 1));
            @(negedge clk);

            if (req_valid) chk("rnd single outstanding", {31'b0, out_b}, 0);
            if (p_rv && !p_rr && !p_fl) begin
                chk("rnd req held", {31'b0, req_valid}, 1);
                chk("rnd req addr held", req_addr, p_ra);
            end
            if (p_iv && !p_ir && !p_fl) begin
                chk("rnd inst held", {31'b0, inst_valid}, 1);
                chk("rnd inst stable", inst, p_in);
                chk("rnd inst_pc stable", inst_pc, p_ipc);
                chk("rnd fault stable", {31'b0, inst_fault}, {31'b0, p_f});
            end
            chk("rnd pc_advance", {31'b0, pc_advance}, {31'b0, inst_valid && inst_ready && !flush});

            acc = inst_valid && inst_ready && !flush;
            hs  = req_valid && req_ready;
            if (acc) begin
                deliv++;
                chk("rnd inst_pc", inst_pc, pcr);
                if (pcr[1:0] != 2'b00) begin
                    chk("rnd misaligned inst", inst, NOP);
                    chk("rnd misaligned fault", {31'b0, inst_fault}, 1);
                end else if (cst == 2) begin
                    chk("rnd inst", inst, cerr ? NOP : cdata);
                    chk("rnd fault", {31'b0, inst_fault}, {31'b0, cerr});
                end else if (cst == 1) begin
                    chk("rnd timeout inst", inst, NOP);
                    chk("rnd timeout fault", {31'b0, inst_fault}, 1);
                    chk("rnd timeout age", {31'b0, cnt >= TO}, 1);
                end else begin
                    chk("rnd delivery without fetch", {31'b0, acc}, 0);
                end
            end
            if (hs && pcr[1:0] != 2'b00) chk("rnd misaligned request", req_addr, pcr);

            if (rsp_valid) begin
                out_b = 0;
                if (cst == 1 && !flush) begin cst = 2; cdata = memf(oaddr); cerr = oerr; end
            end
            fresh = 0;
            if (hs) begin
                chk("rnd req addr", req_addr, pcr);
                out_b = 1; oaddr = req_addr; cnt = 0; rel = 0; rcnt = 0;
                late = ($urandom_range(0, 4) == 0);
                lat  = $urandom_range(0, TO - 1);
                oerr = ($urandom_range(0, 7) == 0);
                if (!flush) cst = 1;
            end else if (out_b) begin
                cnt++;
            end
            if (acc || flush) begin
                pcr = newpc();
                cst = 0;
                if (out_b && late && !rel) begin rel = 1; rcnt = $urandom_range(0, 2); fresh = 1; end
            end
            if (rel && !fresh && rcnt > 0) rcnt--;

            p_rv = req_valid; p_rr = req_ready; p_fl = flush; p_iv = inst_valid;
            p_ir = inst_ready; p_f = inst_fault; p_ra = req_addr; p_in = inst; p_ipc = inst_pc;
            tick();
        end
        chk("rnd deliveries made", {31'b0, deliv >= 50}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
